// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regs
// Description : APB completer for one peripheral slot. Decodes its slot from
//               sel_port, runs the setup/access handshake with a programmable
//               number of wait states and backs a word-addressed register
//               file whose register 0 is a read-only ID.
//               Optional macro APB_SLVERR_EN enables the err response for
//               out-of-range accesses and writes to the ID register.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regs #(
    parameter logic [2:0]  PORT_ID     = 3'd2,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel_port,
    input  logic        en,
    input  logic        wr,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         c_IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_WAIT   = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         w_latch;
    logic         w_hit;
    logic [5:0]   w_idx_in;
    logic         w_valid_in;
    logic         w_enter_access;
    logic [31:0]  w_rd_val;

    logic         r_wr;
    logic [5:0]   r_idx;
    logic         r_valid;
    logic [31:0]  r_wdata;
    logic [3:0]   r_cnt;
    logic         r_ready;
    logic [31:0]  r_rdata;
    logic [31:0]  r_regs [NUM_REGS];

    // Upper address bits select the slot at the interconnect; byte lane bits
    // are meaningless for word registers.
    logic w_unused;
    assign w_unused = &{1'b0, addr[11:8], addr[1:0]};

    assign w_hit          = (sel_port == PORT_ID);
    assign w_idx_in       = addr[7:2];
    assign w_valid_in     = ({1'b0, w_idx_in} < 7'(NUM_REGS));
    assign w_enter_access = (w_next == S_ACCESS);

    // Read value for the latched word offset; ID for 0, zero when out of range.
    always_comb begin
        w_rd_val = 32'd0;
        if (r_idx == 6'd0) begin
            w_rd_val = ID_VALUE;
        end else if (r_valid) begin
            w_rd_val = r_regs[r_idx[c_IDX_W-1:0]];
        end
    end

    // Next-state decode and input-capture strobe for the handshake.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            S_IDLE: begin
                // en without a preceding setup phase is a protocol violation: ignored
                if (w_hit && !en) begin
                    w_next  = S_SETUP;
                    w_latch = 1'b1;
                end
            end
            S_SETUP: begin
                if (!w_hit) begin
                    w_next = S_IDLE;
                end else if (en) begin
                    w_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                end else begin
                    // master stalling in setup; keep tracking its inputs
                    w_latch = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_hit && en) begin
                    if (r_cnt == 4'd0) begin
                        w_next = S_ACCESS;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (w_hit && !en) begin
                    w_next  = S_SETUP;
                    w_latch = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, wait counter and latched transfer attributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_idx   <= 6'd0;
            r_valid <= 1'b0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_SETUP && w_next == S_WAIT) begin
                r_cnt <= c_WAIT_INIT;
            end else if (r_state == S_WAIT && w_next == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_latch) begin
                r_wr    <= wr;
                r_idx   <= w_idx_in;
                r_valid <= w_valid_in;
                r_wdata <= wdata;
            end
        end
    end

    // Completion pulse and read data, both registered on entry to ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ready <= w_enter_access;
            if (w_enter_access && !r_wr) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // Register file; the write commits on the edge that leaves ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (r_state == S_ACCESS && r_wr && r_valid && r_idx != 6'd0) begin
            r_regs[r_idx[c_IDX_W-1:0]] <= r_wdata;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;

`ifdef APB_SLVERR_EN
    logic r_err;

    // Error pulse coincides with ready for out-of-range or ID-register writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_enter_access && (!r_valid || (r_wr && r_idx == 6'd0));
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_slave_regs
// Description : Directed self-checking bench for apb_slave_regs. Three
//               instances share the bus, each on its own slot with a
//               different wait-state count (slot 2: 1, slot 4: 3, slot 5: 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regs;

`ifdef APB_SLVERR_EN
    localparam logic c_ERR_ON = 1'b1;
`else
    localparam logic c_ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  sel_port;
    logic        en;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;

    logic        ready_a, ready_b, ready_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        err_a, err_b, err_c;

    int n_checks = 0;
    int n_fail   = 0;

    apb_slave_regs #(.PORT_ID(3'd2), .NUM_REGS(8), .WAIT_CYCLES(1), .ID_VALUE(32'h0000_0200)) u_dut_a (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr(wr), .addr(addr),
        .wdata(wdata), .ready(ready_a), .rdata(rdata_a), .err(err_a));

    apb_slave_regs #(.PORT_ID(3'd4), .NUM_REGS(8), .WAIT_CYCLES(3), .ID_VALUE(32'h0000_0200)) u_dut_b (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr(wr), .addr(addr),
        .wdata(wdata), .ready(ready_b), .rdata(rdata_b), .err(err_b));

    apb_slave_regs #(.PORT_ID(3'd5), .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(32'h0000_0200)) u_dut_c (
        .clk(clk), .rst(rst), .sel_port(sel_port), .en(en), .wr(wr), .addr(addr),
        .wdata(wdata), .ready(ready_c), .rdata(rdata_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sel_ready(input logic [2:0] s);
        case (s)
            3'd2:    return ready_a;
            3'd4:    return ready_b;
            3'd5:    return ready_c;
            default: return ready_a | ready_b | ready_c;
        endcase
    endfunction

    function automatic logic [31:0] sel_rdata(input logic [2:0] s);
        case (s)
            3'd2:    return rdata_a;
            3'd4:    return rdata_b;
            default: return rdata_c;
        endcase
    endfunction

    function automatic logic sel_err(input logic [2:0] s);
        case (s)
            3'd2:    return err_a;
            3'd4:    return err_b;
            default: return err_c;
        endcase
    endfunction

    // One transfer: setup cycle, then en until ready (bounded). Returns at the
    // falling edge inside the ready cycle with the bus back at slot 0.
    task automatic apb_xfer(input logic [2:0] s, input logic w, input logic [11:0] a,
                            input logic [31:0] d, input logic scramble,
                            output int lat, output logic [31:0] rd, output logic e,
                            output logic got);
        got = 1'b0; lat = 0; rd = 32'd0; e = 1'b0;
        @(negedge clk);
        sel_port = s; wr = w; addr = a; wdata = d; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        if (scramble) begin
            addr  = 12'h2FC;
            wdata = ~d;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel_ready(s)) begin
                got = 1'b1; lat = k; rd = sel_rdata(s); e = sel_err(s);
                break;
            end
        end
        en = 1'b0; sel_port = 3'd0;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({ready_a, ready_b, ready_c} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=000", {ready_a, ready_b, ready_c});
        end
        n_checks++;
        if ((rdata_a | rdata_b | rdata_c) !== 32'd0) begin
            n_fail++; $display("FAIL reset_rdata got=%h/%h/%h exp=0", rdata_a, rdata_b, rdata_c);
        end
        n_checks++;
        if ({err_a, err_b, err_c} !== 3'b000) begin
            n_fail++; $display("FAIL reset_err got=%b exp=000", {err_a, err_b, err_c});
        end
    endtask

    task automatic test_id_read;
        int lat; logic [31:0] rd; logic e, got;
        apb_xfer(3'd2, 1'b0, 12'h200, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || lat != 2) begin
            n_fail++; $display("FAIL id_latency got=%0d (seen %b) exp=2", lat, got);
        end
        n_checks++;
        if (rd !== 32'h0000_0200) begin
            n_fail++; $display("FAIL id_rdata got=%h exp=00000200", rd);
        end
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL id_err got=%b exp=0", e);
        end
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] rd; logic e, got;
        // address/data are changed after setup; the latched values must win
        apb_xfer(3'd2, 1'b1, 12'h204, 32'hDEAD_BEEF, 1'b1, lat, rd, e, got);
        n_checks++;
        if (!got || lat != 2) begin
            n_fail++; $display("FAIL wr_latency got=%0d (seen %b) exp=2", lat, got);
        end
        n_checks++;
        if (rd !== 32'h0000_0200) begin
            n_fail++; $display("FAIL wr_keeps_rdata got=%h exp=00000200", rd);
        end
        apb_xfer(3'd2, 1'b0, 12'h204, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || lat != 2 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_204 got=%h lat=%0d exp=deadbeef lat=2", rd, lat);
        end
        apb_xfer(3'd2, 1'b0, 12'h2FC, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (rd !== 32'h0000_0000) begin
            n_fail++; $display("FAIL rd_2fc_from_scramble got=%h exp=0", rd);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic e, got;
        apb_xfer(3'd2, 1'b0, 12'h2FC, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || rd !== 32'd0) begin
            n_fail++; $display("FAIL oor_rdata got=%h (seen %b) exp=0", rd, got);
        end
        n_checks++;
        if (e !== c_ERR_ON) begin
            n_fail++; $display("FAIL oor_err got=%b exp=%b", e, c_ERR_ON);
        end
        @(negedge clk);
        n_checks++;
        if (err_a !== 1'b0) begin
            n_fail++; $display("FAIL err_after_ready got=%b exp=0", err_a);
        end
        apb_xfer(3'd2, 1'b1, 12'h200, 32'h0000_1234, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || e !== c_ERR_ON) begin
            n_fail++; $display("FAIL id_write_err got=%b (seen %b) exp=%b", e, got, c_ERR_ON);
        end
        apb_xfer(3'd2, 1'b0, 12'h200, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (rd !== 32'h0000_0200 || e !== 1'b0) begin
            n_fail++; $display("FAIL id_after_write got=%h err=%b exp=00000200 err=0", rd, e);
        end
    endtask

    task automatic test_other_slot;
        int lat; logic [31:0] rd; logic e, got;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        sel_port = 3'd3; wr = 1'b1; addr = 12'h204; wdata = 32'h0000_5555; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ready_a | ready_b | ready_c) seen = 1'b1;
        end
        en = 1'b0; sel_port = 3'd0;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL other_slot_ready got=%b exp=0", seen);
        end
        n_checks++;
        if (rdata_a !== 32'h0000_0200) begin
            n_fail++; $display("FAIL other_slot_rdata got=%h exp=00000200", rdata_a);
        end
        apb_xfer(3'd2, 1'b0, 12'h204, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL other_slot_reg got=%h exp=deadbeef", rd);
        end
    endtask

    task automatic test_abort;
        int lat; logic [31:0] rd; logic e, got;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        sel_port = 3'd4; wr = 1'b1; addr = 12'h208; wdata = 32'hA5A5_A5A5; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);                 // now in WAIT
        en = 1'b0; sel_port = 3'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready_b) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL abort_ready got=%b exp=0", seen);
        end
        apb_xfer(3'd4, 1'b0, 12'h208, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || lat != 4 || rd !== 32'd0) begin
            n_fail++; $display("FAIL abort_reg got=%h lat=%0d exp=0 lat=4", rd, lat);
        end
    endtask

    task automatic test_back_to_back;
        int first, second;
        first = -1; second = -1;
        @(negedge clk);
        sel_port = 3'd5; wr = 1'b1; addr = 12'h20C; wdata = 32'h0000_0001; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (ready_c && first < 0) begin
                first = k;
                en = 1'b0; wr = 1'b0; wdata = 32'hFFFF_FFFF;   // next setup, same slot
            end else if (ready_c) begin
                second = k;
                break;
            end else if (first >= 0) begin
                en = 1'b1;
            end
        end
        en = 1'b0; sel_port = 3'd0;
        n_checks++;
        if (first != 1 || second - first != 2) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d,%0d exp=1,3", first, second);
        end
        n_checks++;
        if (rdata_c !== 32'h0000_0001) begin
            n_fail++; $display("FAIL b2b_rdata got=%h exp=00000001", rdata_c);
        end
    endtask

    task automatic test_mid_reset;
        int lat; logic [31:0] rd; logic e, got;
        logic seen;
        seen = 1'b0;
        apb_xfer(3'd4, 1'b0, 12'h200, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || lat != 4 || rd !== 32'h0000_0200) begin
            n_fail++; $display("FAIL w3_id got=%h lat=%0d exp=00000200 lat=4", rd, lat);
        end
        @(negedge clk);
        sel_port = 3'd4; wr = 1'b0; addr = 12'h200; en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);                 // in WAIT
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready_b !== 1'b0 || rdata_b !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset got ready=%b rdata=%h exp=0/0", ready_b, rdata_b);
        end
        rst = 1'b0; en = 1'b0; sel_port = 3'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready_b) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_ready got=%b exp=0", seen);
        end
        apb_xfer(3'd2, 1'b0, 12'h204, 32'd0, 1'b0, lat, rd, e, got);
        n_checks++;
        if (!got || rd !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_reg got=%h exp=0", rd);
        end
    endtask

    initial begin
        rst = 1'b1; sel_port = 3'd0; en = 1'b0; wr = 1'b0; addr = 12'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_id_read();
        test_write_read();
        test_errors();
        test_other_slot();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
